// File: rtl/serial_alu_if.sv
// ============================================================================
// Module      : serial_alu_if
// Description : Request/response bundle between an ALU op issuer and serial_alu.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface serial_alu_if #(
    parameter int WIDTH = 32
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             resp_valid;
    logic             resp_ready;
    logic [WIDTH-1:0] result;
    logic             carryout;
    logic             zero;
    logic             overflow;

    modport master (
        output req_valid, a, b, op, resp_ready,
        input  req_ready, resp_valid, result, carryout, zero, overflow
    );

    modport slave (
        input  req_valid, a, b, op, resp_ready,
        output req_ready, resp_valid, result, carryout, zero, overflow
    );
endinterface

`default_nettype wire

// File: rtl/serial_alu.sv
// ============================================================================
// Module      : serial_alu
// Description : Bit-serial 32-bit ALU, one result bit per clock, valid/ready I/O.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_alu #(
    parameter int WIDTH = 32
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    serial_alu_if.slave     bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] c_LAST = CW'(WIDTH - 1);

    localparam logic [2:0] c_OP_ADD  = 3'b000;
    localparam logic [2:0] c_OP_SUB  = 3'b001;
    localparam logic [2:0] c_OP_XOR  = 3'b010;
    localparam logic [2:0] c_OP_SLT  = 3'b011;
    localparam logic [2:0] c_OP_AND  = 3'b100;
    localparam logic [2:0] c_OP_NAND = 3'b101;
    localparam logic [2:0] c_OP_NOR  = 3'b110;
    localparam logic [2:0] c_OP_OR   = 3'b111;

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_SHIFT = 2'd1;
    localparam logic [1:0] c_S_DONE  = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_op;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic [WIDTH-1:0] r_res;
    logic             r_co;
    logic             r_ovf;
    logic             r_zero;

    logic             w_req_ready;
    logic             w_resp_valid;
    logic             w_accept;
    logic             w_last;
    logic             w_binv;
    logic             w_b_eff;
    logic             w_sum;
    logic             w_cout;
    logic             w_ovf;
    logic             w_bit;
    logic             w_is_arith;
    logic             w_is_slt;
    logic [WIDTH-1:0] w_final;

    assign w_accept   = bus.req_valid && w_req_ready;
    assign w_last     = (r_cnt == c_LAST);
    assign w_is_arith = (r_op == c_OP_ADD) || (r_op == c_OP_SUB);
    assign w_is_slt   = (r_op == c_OP_SLT);
    // SLT is evaluated as a full a-b, so it shares the inverted-b path with SUB
    assign w_binv     = (r_op == c_OP_SUB) || w_is_slt;
    assign w_b_eff    = r_b[0] ^ w_binv;
    assign w_sum      = r_a[0] ^ w_b_eff ^ r_carry;
    assign w_cout     = (r_a[0] & w_b_eff) | (r_a[0] & r_carry) | (w_b_eff & r_carry);
    assign w_ovf      = r_carry ^ w_cout;

    always_comb begin
        w_bit = 1'b0;
        case (r_op)
            c_OP_ADD, c_OP_SUB, c_OP_SLT: w_bit = w_sum;
            c_OP_XOR:  w_bit = r_a[0] ^ r_b[0];
            c_OP_AND:  w_bit = r_a[0] & r_b[0];
            c_OP_NAND: w_bit = ~(r_a[0] & r_b[0]);
            c_OP_NOR:  w_bit = ~(r_a[0] | r_b[0]);
            c_OP_OR:   w_bit = r_a[0] | r_b[0];
            default:   w_bit = 1'b0;
        endcase
    end

    assign w_final = w_is_slt ? {{(WIDTH-1){1'b0}}, w_sum ^ w_ovf}
                              : {w_bit, r_res[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE:  if (bus.req_valid) w_state_nxt = c_S_SHIFT;
            c_S_SHIFT: if (w_last)        w_state_nxt = c_S_DONE;
            c_S_DONE:  if (bus.resp_ready) w_state_nxt = c_S_IDLE;
            default:   w_state_nxt = c_S_IDLE;
        endcase
    end

    always_comb begin
        w_req_ready  = 1'b0;
        w_resp_valid = 1'b0;
        case (r_state)
            c_S_IDLE: w_req_ready  = 1'b1;
            c_S_DONE: w_resp_valid = 1'b1;
            default: begin
                w_req_ready  = 1'b0;
                w_resp_valid = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= 3'b000;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_res   <= '0;
            r_co    <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
        end else if (w_accept) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_op    <= bus.op;
            r_cnt   <= '0;
            r_carry <= (bus.op == c_OP_SUB) || (bus.op == c_OP_SLT);
        end else if (r_state == c_S_SHIFT) begin
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_carry <= w_cout;
            if (w_last) begin
                r_res  <= w_final;
                r_co   <= w_is_arith & w_cout;
                r_ovf  <= w_is_arith & w_ovf;
                r_zero <= (w_final == '0);
            end else begin
                r_cnt  <= r_cnt + 1'b1;
                r_res  <= {w_bit, r_res[WIDTH-1:1]};
            end
        end
    end

    assign bus.req_ready  = w_req_ready;
    assign bus.resp_valid = w_resp_valid;
    assign bus.result     = r_res;
    assign bus.carryout   = r_co;
    assign bus.overflow   = r_ovf;
    assign bus.zero       = r_zero;

endmodule

`default_nettype wire

// File: tb/tb_serial_alu.sv
// ============================================================================
// Module      : tb_serial_alu
// Description : Directed and random checks of serial_alu against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_alu;
    localparam int WIDTH = 32;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    serial_alu_if #(.WIDTH(WIDTH)) alu_bus ();

    serial_alu #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (alu_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference result as {overflow, carryout, zero, result}
    function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
        logic [32:0] s;
        logic [31:0] r;
        logic        co;
        logic        ov;
        co = 1'b0;
        ov = 1'b0;
        r  = '0;
        s  = '0;
        case (op)
            3'd0: begin
                s  = {1'b0, a} + {1'b0, b};
                r  = s[31:0];
                co = s[32];
                ov = (a[31] == b[31]) && (r[31] != a[31]);
            end
            3'd1: begin
                s  = {1'b0, a} + {1'b0, ~b} + 33'd1;
                r  = s[31:0];
                co = s[32];
                ov = (a[31] != b[31]) && (r[31] != a[31]);
            end
            3'd2: r = a ^ b;
            3'd3: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd4: r = a & b;
            3'd5: r = ~(a & b);
            3'd6: r = ~(a | b);
            default: r = a | b;
        endcase
        return {ov, co, (r == 32'd0), r};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [31:0] ta, input logic [31:0] tb, input logic [2:0] top,
                         input int hold, input bit disturb, input string tag);
        logic [34:0] exp;
        int          lat;
        exp = model(ta, tb, top);
        alu_bus.a         = ta;
        alu_bus.b         = tb;
        alu_bus.op        = top;
        alu_bus.req_valid = 1'b1;
        check({tag, ".req_ready"}, {31'd0, alu_bus.req_ready}, 32'd1);
        tick();
        alu_bus.req_valid = 1'b0;
        lat = 0;
        while (lat < 100) begin
            if (disturb) begin
                alu_bus.a  = $urandom;
                alu_bus.b  = $urandom;
                alu_bus.op = 3'($urandom_range(0, 7));
            end
            tick();
            lat++;
            if (alu_bus.resp_valid) break;
        end
        check({tag, ".latency"}, lat, WIDTH);
        check({tag, ".result"}, alu_bus.result, exp[31:0]);
        check({tag, ".carryout"}, {31'd0, alu_bus.carryout}, {31'd0, exp[33]});
        check({tag, ".overflow"}, {31'd0, alu_bus.overflow}, {31'd0, exp[34]});
        check({tag, ".zero"}, {31'd0, alu_bus.zero}, {31'd0, exp[32]});
        for (int i = 0; i < hold; i++) begin
            alu_bus.a = $urandom;
            tick();
            check({tag, ".hold_valid"}, {31'd0, alu_bus.resp_valid}, 32'd1);
            check({tag, ".hold_ready"}, {31'd0, alu_bus.req_ready}, 32'd0);
            check({tag, ".hold_result"}, alu_bus.result, exp[31:0]);
        end
        alu_bus.resp_ready = 1'b1;
        tick();
        alu_bus.resp_ready = 1'b0;
        check({tag, ".post_req_ready"}, {31'd0, alu_bus.req_ready}, 32'd1);
        check({tag, ".post_resp_valid"}, {31'd0, alu_bus.resp_valid}, 32'd0);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [2:0]  rop;
        int          stale;
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        alu_bus.req_valid  = 1'b0;
        alu_bus.resp_ready = 1'b0;
        alu_bus.a  = '0;
        alu_bus.b  = '0;
        alu_bus.op = 3'd0;
        repeat (3) tick();
        check("reset.result", alu_bus.result, 32'd0);
        check("reset.flags", {29'd0, alu_bus.carryout, alu_bus.overflow, alu_bus.zero}, 32'd0);
        check("reset.resp_valid", {31'd0, alu_bus.resp_valid}, 32'd0);
        check("reset.req_ready", {31'd0, alu_bus.req_ready}, 32'd1);
        rst_n = 1'b1;
        tick();

        do_op(32'h000FFFFF, 32'h00000001, 3'd0, 0, 1'b0, "add_basic");
        do_op(32'hFFFFFFFF, 32'h00000001, 3'd0, 0, 1'b0, "add_wrap");
        do_op(32'h80000000, 32'h00000001, 3'd1, 0, 1'b0, "sub_ovf");
        do_op(32'd1, 32'd2, 3'd3, 0, 1'b0, "slt_1_2");
        do_op(32'd8, 32'd2, 3'd3, 0, 1'b0, "slt_8_2");
        do_op(32'h80000008, 32'd2, 3'd3, 0, 1'b0, "slt_neg_pos");
        do_op(32'd8, 32'h80000002, 3'd3, 0, 1'b0, "slt_pos_neg");
        do_op(32'h80000008, 32'h80000002, 3'd3, 0, 1'b0, "slt_neg_neg");
        do_op(32'd7, 32'd7, 3'd3, 0, 1'b0, "slt_equal");
        do_op(32'd0, 32'd1, 3'd2, 5, 1'b0, "xor_hold");
        do_op(32'hF0F0F0F0, 32'hFF00FF00, 3'd4, 0, 1'b0, "and");
        do_op(32'hF0F0F0F0, 32'hFF00FF00, 3'd5, 0, 1'b0, "nand");
        do_op(32'hF0F0F0F0, 32'hFF00FF00, 3'd6, 0, 1'b0, "nor");
        do_op(32'hF0F0F0F0, 32'hFF00FF00, 3'd7, 0, 1'b0, "or");
        do_op(32'h12345678, 32'h0F0F0F0F, 3'd1, 0, 1'b1, "sub_disturb");

        // Abort mid-operation: reset lands in the 10th SHIFT cycle
        alu_bus.a  = 32'h55555555;
        alu_bus.b  = 32'h33333333;
        alu_bus.op = 3'd0;
        alu_bus.req_valid = 1'b1;
        tick();
        alu_bus.req_valid = 1'b0;
        repeat (9) tick();
        rst_n = 1'b0;
        #1;
        check("abort.result", alu_bus.result, 32'd0);
        check("abort.flags", {29'd0, alu_bus.carryout, alu_bus.overflow, alu_bus.zero}, 32'd0);
        check("abort.resp_valid", {31'd0, alu_bus.resp_valid}, 32'd0);
        check("abort.req_ready", {31'd0, alu_bus.req_ready}, 32'd1);
        tick();
        rst_n = 1'b1;
        stale = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (alu_bus.resp_valid) stale++;
        end
        check("abort.stale_resp", stale, 0);
        do_op(32'd2, 32'd3, 3'd0, 0, 1'b0, "add_after_abort");

        for (int i = 0; i < 24; i++) begin
            ra  = $urandom;
            rb  = (i % 6 == 0) ? ra : $urandom;
            rop = 3'($urandom_range(0, 7));
            do_op(ra, rb, rop, int'($urandom_range(0, 3)), 1'(i % 2), "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
